// File: rtl/alu_chk_pkg.sv
// Shared types and widths for the ALU result checker and its expected-result FIFO.
package alu_chk_pkg;

  localparam int ALU_IN_W  = 16;
  localparam int ALU_OUT_W = 17;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } chk_state_e;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4
  } alu_op_e;

endpackage

// File: rtl/alu_chk_fifo.sv
// Synchronous FIFO for expected results; head word is visible combinationally so it
// can be compared on the same edge that pops it. Overflow/underflow requests are ignored.
module alu_chk_fifo #(
  parameter int DATA_WIDTH = 17,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_LVL = (AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == DEPTH_LVL);
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_result_checker.sv
// In-order scoreboard: queues expected ALU results and compares one per observed output.
// Define ALU_CHK_HALT_ON_ERR_EN to freeze checking on the first mismatch/underflow until clear.
module alu_result_checker
  import alu_chk_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_OUT_W,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   exp_valid,
  output logic                   exp_ready,
  input  logic [DATA_WIDTH-1:0]  exp_data,
  input  logic                   act_valid,
  input  logic [DATA_WIDTH-1:0]  act_data,
  output logic                   chk_valid,
  output logic                   chk_pass,
  output logic [DATA_WIDTH-1:0]  chk_exp,
  output logic [DATA_WIDTH-1:0]  chk_act,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic [CNT_W-1:0]       underflow_cnt,
  output logic [$clog2(DEPTH):0] level,
  output logic                   all_ok
);

  chk_state_e            state;
  chk_state_e            state_next;
  logic [DATA_WIDTH-1:0] head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  act_take;
  logic                  do_pop;
  logic                  underflow;
  logic                  mismatch;
  logic                  match;

  // No bypass: emptiness is judged before any same-cycle push lands.
  assign act_take  = act_valid && (state == ST_RUN) && !clear;
  assign underflow = act_take && fifo_empty;
  assign do_pop    = act_take && !fifo_empty;
  assign mismatch  = do_pop && (head != act_data);
  assign match     = do_pop && (head == act_data);
  assign exp_ready = !fifo_full && (state == ST_RUN);
  assign all_ok    = (level == '0) && (mismatch_cnt == '0) && (underflow_cnt == '0);

  alu_chk_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear),
    .push      (exp_valid && exp_ready),
    .push_data (exp_data),
    .pop       (do_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_RUN;
    end
`ifdef ALU_CHK_HALT_ON_ERR_EN
    else if ((state == ST_RUN) && (mismatch || underflow)) begin
      state_next = ST_HALT;
    end
`endif
  end

  // While halted act_take is low, so the captured chk_* keep the failing values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_valid     <= 1'b0;
      chk_pass      <= 1'b0;
      chk_exp       <= '0;
      chk_act       <= '0;
      match_cnt     <= '0;
      mismatch_cnt  <= '0;
      underflow_cnt <= '0;
    end else if (clear) begin
      chk_valid     <= 1'b0;
      chk_pass      <= 1'b0;
      chk_exp       <= '0;
      chk_act       <= '0;
      match_cnt     <= '0;
      mismatch_cnt  <= '0;
      underflow_cnt <= '0;
    end else begin
      chk_valid <= act_take;
      if (act_take) begin
        chk_pass <= match;
        chk_exp  <= fifo_empty ? '0 : head;
        chk_act  <= act_data;
      end
      if (match && (match_cnt != '1))           match_cnt     <= match_cnt + 1'b1;
      if (mismatch && (mismatch_cnt != '1))     mismatch_cnt  <= mismatch_cnt + 1'b1;
      if (underflow && (underflow_cnt != '1))   underflow_cnt <= underflow_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker; counters are narrowed to 4 bits so saturation is reachable.
// Build with ALU_CHK_HALT_ON_ERR_EN defined to exercise the halt-on-error variant.
module tb_alu_result_checker;

  localparam int DW    = 17;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          exp_valid;
  logic          exp_ready;
  logic [DW-1:0] exp_data;
  logic          act_valid;
  logic [DW-1:0] act_data;
  logic          chk_valid;
  logic          chk_pass;
  logic [DW-1:0] chk_exp;
  logic [DW-1:0] chk_act;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] mismatch_cnt;
  logic [CW-1:0] underflow_cnt;
  logic [3:0]    level;
  logic          all_ok;

  int checks = 0;
  int errors = 0;

  alu_result_checker #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .exp_valid     (exp_valid),
    .exp_ready     (exp_ready),
    .exp_data      (exp_data),
    .act_valid     (act_valid),
    .act_data      (act_data),
    .chk_valid     (chk_valid),
    .chk_pass      (chk_pass),
    .chk_exp       (chk_exp),
    .chk_act       (chk_act),
    .match_cnt     (match_cnt),
    .mismatch_cnt  (mismatch_cnt),
    .underflow_cnt (underflow_cnt),
    .level         (level),
    .all_ok        (all_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exp_valid = 1'b0;
    act_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    exp_valid = 1'b1;
    exp_data  = d;
    step();
    exp_valid = 1'b0;
  endtask

  task automatic act(input logic [DW-1:0] d);
    act_valid = 1'b1;
    act_data  = d;
    step();
    act_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    exp_valid = 1'b0;
    exp_data  = '0;
    act_valid = 1'b0;
    act_data  = '0;
    step();
    step();
    reset = 1'b0;
    step();

    check("rst_exp_ready", 32'(exp_ready), 32'd1);
    check("rst_all_ok",    32'(all_ok),    32'd1);
    check("rst_level",     32'(level),     32'd0);
    check("rst_chk_valid", 32'(chk_valid), 32'd0);
    check("rst_match_cnt", 32'(match_cnt), 32'd0);

    // Two matching results, including one with the carry bit set.
    push(17'h0_1234);
    push(17'h1_0000);
    check("t1_level", 32'(level), 32'd2);
    act(17'h0_1234);
    check("t1a_valid", 32'(chk_valid), 32'd1);
    check("t1a_pass",  32'(chk_pass),  32'd1);
    check("t1a_act",   32'(chk_act),   32'h0_1234);
    act(17'h1_0000);
    check("t1b_pass",  32'(chk_pass),  32'd1);
    check("t1b_exp",   32'(chk_exp),   32'h1_0000);
    step();
    check("t1_valid_drop", 32'(chk_valid), 32'd0);
    check("t1_match_cnt",  32'(match_cnt), 32'd2);
    check("t1_all_ok",     32'(all_ok),    32'd1);

    // Mismatch.
    push(17'h0_00FF);
    act(17'h0_00FE);
    check("t2_valid",    32'(chk_valid),    32'd1);
    check("t2_pass",     32'(chk_pass),     32'd0);
    check("t2_exp",      32'(chk_exp),      32'h0_00FF);
    check("t2_act",      32'(chk_act),      32'h0_00FE);
    check("t2_mismatch", 32'(mismatch_cnt), 32'd1);
    check("t2_all_ok",   32'(all_ok),       32'd0);
    do_clear();
    check("clr_mismatch",  32'(mismatch_cnt), 32'd0);
    check("clr_match",     32'(match_cnt),    32'd0);
    check("clr_exp_ready", 32'(exp_ready),    32'd1);
    check("clr_all_ok",    32'(all_ok),       32'd1);

    // Fill to DEPTH, then push+pop while full: push refused, pop proceeds.
    for (int i = 0; i < DEPTH; i++) push(DW'(i + 16));
    check("t3_level_full", 32'(level),     32'd8);
    check("t3_ready_full", 32'(exp_ready), 32'd0);
    exp_valid = 1'b1;
    exp_data  = 17'h1_FFFF;
    act(17'd16);
    exp_valid = 1'b0;
    check("t3_level_7", 32'(level),    32'd7);
    check("t3_pass",    32'(chk_pass), 32'd1);
    for (int i = 1; i < DEPTH; i++) act(DW'(i + 16));
    check("t3_last_pass",  32'(chk_pass),  32'd1);
    check("t3_last_exp",   32'(chk_exp),   32'd23);
    check("t3_level_0",    32'(level),     32'd0);
    check("t3_match_cnt",  32'(match_cnt), 32'd8);
    check("t3_no_errors",  32'(all_ok),    32'd1);

    // Underflow with a simultaneous push: no bypass, push still stored.
    exp_valid = 1'b1;
    exp_data  = 17'h5;
    act(17'h5);
    exp_valid = 1'b0;
    check("t4_valid",     32'(chk_valid),     32'd1);
    check("t4_pass",      32'(chk_pass),      32'd0);
    check("t4_exp",       32'(chk_exp),       32'd0);
    check("t4_act",       32'(chk_act),       32'h5);
    check("t4_underflow", 32'(underflow_cnt), 32'd1);
    check("t4_level",     32'(level),         32'd1);
    do_clear();
    check("t4_clr_level", 32'(level),         32'd0);
    check("t4_clr_uflow", 32'(underflow_cnt), 32'd0);

    // Error followed by further activity.
    push(17'd1);
    push(17'd2);
    push(17'd3);
    act(17'd9);
    check("t5_pass",     32'(chk_pass),     32'd0);
    check("t5_mismatch", 32'(mismatch_cnt), 32'd1);
    act(17'd2);
    act(17'd3);
    act(17'd3);
`ifdef ALU_CHK_HALT_ON_ERR_EN
    check("t5h_mismatch",  32'(mismatch_cnt),  32'd1);
    check("t5h_match",     32'(match_cnt),     32'd0);
    check("t5h_uflow",     32'(underflow_cnt), 32'd0);
    check("t5h_exp_ready", 32'(exp_ready),     32'd0);
    check("t5h_valid",     32'(chk_valid),     32'd0);
    check("t5h_hold_exp",  32'(chk_exp),       32'd1);
    check("t5h_hold_act",  32'(chk_act),       32'd9);
    check("t5h_level",     32'(level),         32'd2);
    push(17'd7);
    check("t5h_push_drop", 32'(level),         32'd2);
`else
    check("t5r_mismatch",  32'(mismatch_cnt),  32'd1);
    check("t5r_match",     32'(match_cnt),     32'd2);
    check("t5r_uflow",     32'(underflow_cnt), 32'd1);
    check("t5r_exp_ready", 32'(exp_ready),     32'd1);
    check("t5r_chk_exp",   32'(chk_exp),       32'd0);
    check("t5r_level",     32'(level),         32'd0);
`endif
    do_clear();
    check("t5_clr_ready",    32'(exp_ready),    32'd1);
    check("t5_clr_mismatch", 32'(mismatch_cnt), 32'd0);
    check("t5_clr_level",    32'(level),        32'd0);
    check("t5_clr_valid",    32'(chk_valid),    32'd0);

    // Streaming push+pop: level constant, match count saturates at 15.
    push(17'd100);
    for (int i = 0; i < 20; i++) begin
      exp_valid = 1'b1;
      exp_data  = DW'(101 + i);
      act(DW'(100 + i));
      exp_valid = 1'b0;
    end
    check("sat_level",  32'(level),     32'd1);
    check("sat_pass",   32'(chk_pass),  32'd1);
    check("sat_match",  32'(match_cnt), 32'd15);
    act(17'd120);
    check("sat_hold",   32'(match_cnt), 32'd15);

    // Reset mid-stream with an active compare in flight.
    push(17'd30);
    push(17'd31);
    push(17'd32);
    check("t6_level_pre", 32'(level), 32'd3);
    act_valid = 1'b1;
    act_data  = 17'd30;
    #2;
    reset = 1'b1;
    step();
    act_valid = 1'b0;
    check("t6_level",     32'(level),     32'd0);
    check("t6_valid",     32'(chk_valid), 32'd0);
    check("t6_match",     32'(match_cnt), 32'd0);
    check("t6_exp_ready", 32'(exp_ready), 32'd1);
    reset = 1'b0;
    idle();
    step();
    check("t6_post_valid", 32'(chk_valid), 32'd0);
    check("t6_post_ok",    32'(all_ok),    32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
